// File: rtl/gate_sweep_checker.sv
// Exhaustive two-operand sweep of an external gate network. Each vector is checked
// against a selectable bitwise golden function; reports mismatch count and first failure.
module gate_sweep_checker #(
  parameter int N = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [N-1:0]     dut_s,
  output logic [N-1:0]     a_o,
  output logic [N-1:0]     b_o,
  output logic             busy,
  output logic             done,
  output logic [2*N:0]     err_cnt,
  output logic             fail_seen,
  output logic [2*N-1:0]   first_fail
);

  // Handshake: start is a level sampled only in IDLE; busy covers DRIVE and CHECK;
  // done pulses for exactly one cycle once err_cnt/fail_seen/first_fail are final.
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [2*N-1:0] idx;
  logic [1:0]     mode_q;
  logic [N-1:0]   golden;
  logic           mismatch;
  logic           last_vec;

  // Operands come straight from the index register, so they never glitch.
  assign a_o      = idx[2*N-1:N];
  assign b_o      = idx[N-1:0];
  assign last_vec = &idx;

  always_comb begin
    golden = '0;
    case (mode_q)
      2'b00:   golden = ~(a_o & ~b_o);
      2'b01:   golden = ~(~a_o & b_o);
      2'b10:   golden = ~(a_o & b_o);
      default: golden = ~(a_o ^ b_o);
    endcase
  end

  assign mismatch = (state == CHECK) && (dut_s != golden);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = DRIVE;
      end
      DRIVE: begin
        busy      = 1'b1;
        state_nxt = CHECK;
      end
      CHECK: begin
        busy      = 1'b1;
        state_nxt = last_vec ? DONE : DRIVE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= '0;
      mode_q     <= 2'b00;
      err_cnt    <= '0;
      fail_seen  <= 1'b0;
      first_fail <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q     <= mode;
            idx        <= '0;
            err_cnt    <= '0;
            fail_seen  <= 1'b0;
            first_fail <= '0;
          end
        end
        CHECK: begin
          if (mismatch) begin
            err_cnt <= err_cnt + 1'b1;
            if (!fail_seen) begin
              fail_seen  <= 1'b1;
              first_fail <= idx;
            end
          end
          // idx stays at all-ones after the final vector; the next start rewinds it.
          if (!last_vec) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Parametrised, sequential successor to the two-input gate exercises. It sweeps every combination of two N-bit operands, drives them to an external gate-level unit under test, and compares the returned N-bit result against an internal golden model of a selectable two-input function. It reports the mismatch count and the first failing vector. It sits between a stimulus controller (start/done handshake) and any combinational gate network built in the course labs.

## Interface

Parameters:
- N, default 2: width of each operand and of the result; the sweep covers 2^(2N) vectors.

Ports:
- clk input 1: single clock; all state changes on the rising edge.
- reset input 1: asynchronous, active-high; clears all state immediately.
- start input 1: request a sweep; sampled only in IDLE.
- mode input 2: golden function, applied bitwise. 00 = ~(a & ~b); 01 = ~(~a & b); 10 = ~(a & b); 11 = ~(a ^ b). Latched on the accepted start.
- dut_s input N: result returned by the unit under test for the current a_o/b_o.
- a_o output N: operand a driven to the unit under test (registered).
- b_o output N: operand b driven to the unit under test (registered).
- busy output 1: high while a sweep is in progress (DRIVE/CHECK).
- done output 1: single-cycle pulse when a sweep completes.
- err_cnt output 2N+1: number of mismatching vectors in the last sweep.
- fail_seen output 1: at least one mismatch in the last sweep.
- first_fail output 2N: index {a,b} of the first mismatching vector; valid only when fail_seen=1.

## Operation

- Vector index idx is 2N bits wide. a_o = idx[2N-1:N] and b_o = idx[N-1:0], registered from idx.
- States: IDLE, DRIVE, CHECK, DONE.
  - IDLE: if start=1, latch mode, set idx=0 and a_o=b_o=0, clear err_cnt, fail_seen and first_fail, then go to DRIVE. Otherwise hold.
  - DRIVE: a_o/b_o are stable for one full cycle, giving the combinational unit under test time to settle. Go to CHECK.
  - CHECK: at the edge leaving CHECK, compare dut_s with golden(a_o, b_o, mode_latched).
    - On mismatch (any bit differs): increment err_cnt. If fail_seen=0, set fail_seen and set first_fail=idx.
    - If idx is all ones, go to DONE. Otherwise increment idx, update a_o/b_o and go to DRIVE.
  - DONE: done=1 for this single cycle, then go to IDLE.
- Mismatch counting is per vector, not per bit. The maximum count is 2^(2N), which fits in 2N+1 bits with no saturation needed.
- Results (err_cnt, fail_seen, first_fail) hold after DONE until the next accepted start or reset.
- start while busy or in DONE is ignored; start held high through DONE starts a new sweep from the following IDLE cycle.
- mode changes during a sweep have no effect.
- Reset values: state=IDLE, idx=0, a_o=0, b_o=0, busy=0, done=0, err_cnt=0, fail_seen=0, first_fail=0, latched mode=00.
- Reset asserted mid-sweep aborts immediately; no done pulse is produced.

## Timing

- Let E0 be the edge that accepts start.
  - busy rises after E0.
  - Vector k is driven from E(2k) to E(2k+2) and compared at E(2k+2).
- For N=2 (16 vectors):
  - The last compare happens at E32, where busy falls and DONE is entered.
  - done is high between E32 and E33; IDLE resumes after E33.
  - Total: 2*2^(2N)+1 cycles from accept to return to IDLE.
- The earliest re-start is accepted at E34.
- dut_s must be valid by the end of the CHECK cycle, i.e. within 2 cycles of a_o/b_o changing. A unit under test with one register stage is supported.
- No combinational path from any input to any output.

## Test plan

- N=2, mode=00, DUT = correct bitwise ~(a&~b) -> done after 33 cycles, err_cnt=0, fail_seen=0, a_o/b_o step through 0..3 / 0..3 in order.
- N=2, mode=00, dut_s tied to 0 -> err_cnt=15 (only a=3,b=0 passes), fail_seen=1, first_fail=0.
- N=2, mode=10, DUT = a&b -> err_cnt=16, first_fail=0; then mode=11 with DUT = ~(a^b) -> err_cnt=0 and the previous results are cleared at the new start.
- N=3, mode=01, DUT correct except bit 0 inverted when a=5,b=2 -> err_cnt=1, first_fail=6'b101010, done after 129 cycles.
- start pulsed again and mode changed at cycle 10 of a sweep -> both ignored; results identical to an undisturbed run.
- reset asserted asynchronously mid-sweep (between edges, cycle 7) -> busy, a_o, b_o, err_cnt and fail_seen go to 0 immediately, no done pulse; a later start gives a full, correct sweep.
